// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } mdu_state_t;

    // Cycles from the start edge to the edge that drops done.
    localparam int MDU_LATENCY = 34;

endpackage

// File: rtl/mdu_sign_fix.sv
// Turns the unsigned magnitude result into the final signed HI/LO pair
// for both the multiply and the divide path.
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] mag,
    input  logic               is_div,
    input  logic               neg_res,
    input  logic               neg_rem,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Divide keeps {remainder, quotient}; the remainder follows the dividend's sign.
    always_comb begin
        prod = neg_res ? -mag : mag;
        quot = neg_res ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
        rem  = neg_rem ? -mag[2*WIDTH-1:WIDTH] : mag[2*WIDTH-1:WIDTH];
        if (is_div) begin
            hi = rem;
            lo = quot;
        end else begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit producing the MIPS HI/LO pair
// for MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes while idle.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state;
    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;

    mdu_op_t            op_sel;
    logic               op_is_div;
    logic               use_sign;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // A zero divisor skips sign handling so the raw dividend lands in HI
    // and the all-ones quotient falls straight out of the restoring loop.
    always_comb begin
        op_sel    = mdu_op_t'(op);
        op_is_div = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
        use_sign  = ((op_sel == OP_MULT) || (op_sel == OP_DIV))
                    && !(op_is_div && (B == '0));
        abs_a     = (use_sign && A[WIDTH-1]) ? -A : A;
        abs_b     = (use_sign && B[WIDTH-1]) ? -B : B;
    end

    // acc holds {product hi, multiplier} for multiply and {rem, quot} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .mag     (acc),
        .is_div  (is_div),
        .neg_res (neg_res),
        .neg_rem (neg_rem),
        .hi      (fix_hi),
        .lo      (fix_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            operand <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op_is_div;
                        neg_res <= use_sign && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem <= use_sign && op_is_div && A[WIDTH-1];
                        operand <= op_is_div ? abs_b : abs_a;
                        acc     <= {{WIDTH{1'b0}}, (op_is_div ? abs_a : abs_b)};
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: reference HI/LO from a behavioural model,
// queued at launch and popped when done fires.
module tb_mdu_iter;

    localparam int WIDTH   = 32;
    localparam int RUN_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: return sa * sb;
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        exp_q.push_back(model(o, a, b));
        step();
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 100) begin
            step();
            cycles++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
        reset = 1'b0;
        step();
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL idle_mthi got %h want 12345678", hi); end
        checks++; if (lo !== 32'h1234_5678) begin errors++; $display("[TB] FAIL idle_mtlo got %h want 12345678", lo); end
        #2 reset = 1'b1;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_hilo got %h_%h want 0_0", hi, lo); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_multu_timing();
        int n;
        logic [63:0] exp;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
        checks++; if (n != RUN_LAT) begin errors++; $display("[TB] FAIL busy_cycles got %0d want %0d", n, RUN_LAT); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_with_busy_drop got %b want 1", done); end
        exp = exp_q.pop_front();
        checks++; if (hi !== exp[63:32]) begin errors++; $display("[TB] FAIL multu_max_hi got %h want %h", hi, exp[63:32]); end
        checks++; if (lo !== exp[31:0]) begin errors++; $display("[TB] FAIL multu_max_lo got %h want %h", lo, exp[31:0]); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_one_cycle got %b want 0", done); end
    endtask

    task automatic test_mult();
        logic [65:0] tbl[8];
        logic [63:0] exp;
        int c;
        tbl[0] = {2'b00, 32'hFFFF_FFF9, 32'd6};
        tbl[1] = {2'b00, 32'h8000_0000, 32'h8000_0000};
        tbl[2] = {2'b00, 32'd7, 32'hFFFF_FFFF};
        tbl[3] = {2'b01, 32'h1234_5678, 32'h9ABC_DEF0};
        for (int i = 4; i < 8; i++) tbl[i] = {2'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i][65:64], tbl[i][63:32], tbl[i][31:0]);
            wait_done(c);
            exp = exp_q.pop_front();
            checks++; if (c != RUN_LAT) begin errors++; $display("[TB] FAIL mult_latency[%0d] got %0d want %0d", i, c, RUN_LAT); end
            checks++; if ({hi, lo} !== exp) begin errors++; $display("[TB] FAIL mult_result[%0d] got %h_%h want %h_%h", i, hi, lo, exp[63:32], exp[31:0]); end
            step();
        end
    endtask

    task automatic test_div();
        logic [65:0] tbl[10];
        logic [63:0] exp;
        int c;
        tbl[0] = {2'b10, 32'hFFFF_FFF9, 32'd2};
        tbl[1] = {2'b11, 32'd100, 32'd7};
        tbl[2] = {2'b11, 32'h1234_5678, 32'h0};
        tbl[3] = {2'b10, 32'h8000_0000, 32'hFFFF_FFFF};
        tbl[4] = {2'b10, 32'hFFFF_FFF9, 32'h0};
        tbl[5] = {2'b10, 32'd7, 32'hFFFF_FFFE};
        for (int i = 6; i < 10; i++) tbl[i] = {2'($urandom_range(2, 3)), 32'($urandom), 32'($urandom_range(1, 70000))};
        for (int i = 0; i < 10; i++) begin
            launch(tbl[i][65:64], tbl[i][63:32], tbl[i][31:0]);
            wait_done(c);
            exp = exp_q.pop_front();
            checks++; if (c != RUN_LAT) begin errors++; $display("[TB] FAIL div_latency[%0d] got %0d want %0d", i, c, RUN_LAT); end
            checks++; if ({hi, lo} !== exp) begin errors++; $display("[TB] FAIL div_result[%0d] got %h_%h want %h_%h", i, hi, lo, exp[63:32], exp[31:0]); end
            step();
        end
    endtask

    task automatic test_ignored_while_busy();
        logic [31:0] h0;
        logic [63:0] exp;
        int c;
        h0 = hi;
        launch(2'b01, 32'd3, 32'd5);
        repeat (9) step();
        op = 2'b11; A = 32'd1000; B = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        hi_we = 1'b0;
        checks++; if (hi !== h0) begin errors++; $display("[TB] FAIL hi_hold_in_run got %h want %h", hi, h0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_run got %b want 1", busy); end
        wait_done(c);
        exp = exp_q.pop_front();
        checks++; if (c != RUN_LAT - 12) begin errors++; $display("[TB] FAIL ignored_start_latency got %0d want %0d", c, RUN_LAT - 12); end
        checks++; if ({hi, lo} !== exp) begin errors++; $display("[TB] FAIL ignored_result got %h_%h want %h_%h", hi, lo, exp[63:32], exp[31:0]); end
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        hi_we = 1'b0;
        checks++; if (hi !== 32'hDEAD_BEEF || lo !== 32'd15) begin errors++; $display("[TB] FAIL mthi_after_done got %h_%h want deadbeef_0000000f", hi, lo); end
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL mthi_mtlo_both got %h_%h want cafef00d_cafef00d", hi, lo); end
        hi_we = 1'b1; wdata = 32'h1111_1111;
        launch(2'b01, 32'd2, 32'd2);
        hi_we = 1'b0;
        checks++; if (hi !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL start_beats_mthi got %h want cafef00d", hi); end
        wait_done(c);
        exp = exp_q.pop_front();
        checks++; if (c != RUN_LAT || {hi, lo} !== exp) begin errors++; $display("[TB] FAIL start_with_we_result got %0d %h_%h want %0d %h_%h", c, hi, lo, RUN_LAT, exp[63:32], exp[31:0]); end
        step();
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] exp;
        bit seen;
        int c;
        hi_we = 1'b1; wdata = 32'h55AA_55AA;
        step();
        hi_we = 1'b0;
        launch(2'b11, 32'd1000, 32'd7);
        repeat (19) step();
        #2 reset = 1'b1;
        #1;
        void'(exp_q.pop_front());
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("[TB] FAIL midreset_hilo got %h_%h want 0_0", hi, lo); end
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            step();
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL midreset_no_done got %b want 0", seen); end
        launch(2'b01, 32'd2, 32'd3);
        wait_done(c);
        exp = exp_q.pop_front();
        checks++; if (c != RUN_LAT || {hi, lo} !== exp) begin errors++; $display("[TB] FAIL after_reset_mult got %0d %h_%h want %0d %h_%h", c, hi, lo, RUN_LAT, exp[63:32], exp[31:0]); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        int c;
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(c);
        exp = exp_q.pop_front();
        checks++; if (c != RUN_LAT || {hi, lo} !== exp) begin errors++; $display("[TB] FAIL b2b_first got %0d %h_%h want %0d %h_%h", c, hi, lo, RUN_LAT, exp[63:32], exp[31:0]); end
        launch(2'b11, 32'd50, 32'd6);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept got %b want 1", busy); end
        wait_done(c);
        exp = exp_q.pop_front();
        checks++; if (c != RUN_LAT || {hi, lo} !== exp) begin errors++; $display("[TB] FAIL b2b_second got %0d %h_%h want %0d %h_%h", c, hi, lo, RUN_LAT, exp[63:32], exp[31:0]); end
        step();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'h0;
        B     = 32'h0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'h0;
        step();
        step();
        test_reset();
        test_multu_timing();
        test_mult();
        test_div();
        test_ignored_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the MIPS datapath; produces the HI/LO register pair for MULT, MULTU, DIV and DIVU.
- It is the sequential counterpart to the single-cycle ALU: it takes the same 32-bit A/B operand buses and runs radix-2 shift-add or shift-subtract over 32 cycles.
- The control unit launches an operation with a start pulse and stalls the pipeline on busy.
- MFHI/MFLO read the hi/lo outputs; MTHI/MTLO write them through the hi_we/lo_we ports.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  WIDTH  multiplicand / dividend (rs).
- B  in  WIDTH  multiplier / divisor (rt).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when hi/lo hold a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1, latch op, sign-control flags and operand magnitudes. Go to RUN with count=0 and busy=1.
  - Signed ops (MULT, DIV) take absolute values; unsigned ops pass the operands through.
- RUN: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply: 2*WIDTH-bit product register; add the multiplicand when the product LSB is 1, then shift right (carry kept in an extra bit).
  - Divide: restoring division on a {rem, quot} register; shift left, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
- FIX (one cycle): apply sign correction, write hi/lo, assert done for exactly this one cycle, then return to IDLE with busy=0.
  - MULT: if the operand signs differ, negate the 64-bit product. hi=product[63:32], lo=product[31:0].
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend. lo=quotient, hi=remainder.
- Divide by zero (B=0, DIV or DIVU): no trap; still takes full latency. lo=32'hFFFF_FFFF, hi=A (original, uncorrected dividend).
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. No trap.
- Timing: start sampled at edge E0; busy=1 after E0; RUN spans E1..E32; FIX is the cycle after E32. hi/lo update and done=1 at E33; busy=0 after E33.
  - Total: 34 cycles from start edge to done deassert.
  - busy is high during RUN and FIX (33 cycles).
- A new start is accepted in the cycle after done (back-to-back).
- start while busy: ignored, no queueing.
- hi_we/lo_we:
  - In IDLE, write wdata on the edge.
  - While busy: ignored.
  - Same cycle as start in IDLE: start wins and the write is dropped.
  - hi_we and lo_we together in IDLE: both registers take wdata.
- A, B and op are don't-care except in the start cycle.
- hi/lo hold their values across all non-writing cycles, including during RUN.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op_t enum (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11).
  - mdu_state_t enum (IDLE, RUN, FIX).
  - MDU_LATENCY=34.
- One sub-module: mdu_sign_fix. Combinational; given the magnitude result, the operand signs and the mult/div select, returns the corrected {hi, lo}. Shared by both paths in FIX.

Test Plan:
- MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> done at edge 33: hi=32'hFFFF_FFFE, lo=32'h0000_0001; busy high exactly 33 cycles.
- MULT A=-7 (32'hFFFF_FFF9), B=6 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFD6 (-42).
- DIV A=-7, B=2 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU A=100, B=7 -> lo=14, hi=2.
- DIVU A=32'h1234_5678, B=0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678. DIV A=32'h8000_0000, B=-1 -> lo=32'h8000_0000, hi=0.
- Pulse start again at cycle 10 of a MULTU 3*5, and pulse hi_we (wdata=32'hDEAD_BEEF) at cycle 12 -> both ignored; result hi=0, lo=15. After done, hi_we with 32'hDEAD_BEEF -> hi=32'hDEAD_BEEF.
- Assert reset at cycle 20 of a DIVU -> hi=lo=0, busy=0 immediately; no done pulse. A new MULTU 2*3 after reset deasserts -> lo=6 at the expected latency.
